mii_tx_framer: RTL and testbench

Streaming MII transmit framer. It sits directly upstream of the PHY transmit pins (enet_tx_en / enet_tx_er / enet_tx_data), in the enet_tx_clk domain, and replaces the hard-coded nibble table. It accepts payload bytes (destination MAC through end of payload) on a valid/ready byte stream and emits preamble, SFD, payload nibbles, zero padding to minimum length, and the CRC-32 FCS. It then enforces the inter-frame gap.

---
 rtl/mii_tx_framer.sv | 224 ++++++++++++++++++++++
 tb/tb_mii_tx_framer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mii_tx_framer.sv
// MII transmit framer: preamble/SFD, low-nibble-first payload, zero pad to minimum
// length, CRC-32 FCS and inter-frame gap; every PHY-facing output is registered.
module mii_tx_framer #(
    parameter int unsigned MIN_PAYLOAD      = 60,
    parameter int unsigned IFG_NIBBLES      = 24,
    parameter int unsigned PREAMBLE_NIBBLES = 15
) (
    input  logic       i_clk,
    input  logic       i_nreset,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    input  logic       i_last,
    output logic       o_ready,
    output logic       o_busy,
    output logic       o_underrun,
    output logic       o_frame_done,
    output logic       enet_tx_en,
    output logic       enet_tx_er,
    output logic [3:0] enet_tx_data
);

    typedef enum logic [2:0] {
        S_IDLE, S_PREAMBLE, S_DATA, S_PAD, S_FCS, S_ABORT, S_IFG
    } state_t;

    localparam logic [7:0]  SFD_CNT   = 8'(PREAMBLE_NIBBLES);
    // The IDLE cycle that samples i_valid is the final idle nibble of the gap.
    localparam logic [7:0]  IFG_LAST  = 8'(IFG_NIBBLES - 2);
    localparam logic [10:0] MIN_BYTES = 11'(MIN_PAYLOAD);
    localparam logic [31:0] CRC_POLY  = 32'hEDB88320;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        half_q, half_d;
    logic        last_q, last_d;
    logic [3:0]  hi_q, hi_d;
    logic [10:0] byte_count_q, byte_count_d;
    logic [31:0] crc_q, crc_d;
    logic        tx_en_q, tx_en_d;
    logic        tx_er_q, tx_er_d;
    logic [3:0]  tx_data_q, tx_data_d;
    logic        underrun_q, underrun_d;
    logic        done_q, done_d;
    logic        take_byte, abort, start_fcs, pad_nib;

    function automatic logic [31:0] crc_nib(input logic [31:0] crc, input logic [3:0] nib);
        logic [31:0] c;
        c = crc;
        for (int unsigned i = 0; i < 4; i++) begin
            c = (c[0] ^ nib[i]) ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

    assign o_ready = ((state_q == S_PREAMBLE) && (cnt_q == SFD_CNT)) ||
                     ((state_q == S_DATA) && half_q && !last_q);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        half_d       = half_q;
        last_d       = last_q;
        hi_d         = hi_q;
        byte_count_d = byte_count_q;
        crc_d        = crc_q;
        tx_en_d      = 1'b0;
        tx_er_d      = 1'b0;
        tx_data_d    = '0;
        underrun_d   = 1'b0;
        done_d       = 1'b0;
        take_byte    = 1'b0;
        abort        = 1'b0;
        start_fcs    = 1'b0;
        pad_nib      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (i_valid) begin
                    state_d      = S_PREAMBLE;
                    cnt_d        = '0;
                    byte_count_d = '0;
                    crc_d        = '1;
                    tx_en_d      = 1'b1;
                    tx_data_d    = 4'h5;
                end
            end
            S_PREAMBLE: begin
                if (cnt_q != SFD_CNT) begin
                    cnt_d     = cnt_q + 8'd1;
                    tx_en_d   = 1'b1;
                    tx_data_d = (cnt_d == SFD_CNT) ? 4'hd : 4'h5;
                end else if (i_valid) begin
                    take_byte = 1'b1;
                end else begin
                    abort = 1'b1;
                end
            end
            S_DATA: begin
                if (!half_q) begin
                    half_d    = 1'b1;
                    tx_en_d   = 1'b1;
                    tx_data_d = hi_q;
                    crc_d     = crc_nib(crc_q, hi_q);
                end else if (last_q) begin
                    if (byte_count_q < MIN_BYTES) begin
                        half_d  = 1'b0;
                        pad_nib = 1'b1;
                    end else begin
                        start_fcs = 1'b1;
                    end
                end else if (i_valid) begin
                    take_byte = 1'b1;
                end else begin
                    abort = 1'b1;
                end
            end
            S_PAD: begin
                if (!half_q) begin
                    half_d  = 1'b1;
                    pad_nib = 1'b1;
                end else begin
                    byte_count_d = byte_count_q + 11'd1;
                    if (byte_count_d >= MIN_BYTES) begin
                        start_fcs = 1'b1;
                    end else begin
                        half_d  = 1'b0;
                        pad_nib = 1'b1;
                    end
                end
            end
            S_FCS: begin
                if (cnt_q == 8'd7) begin
                    state_d = S_IFG;
                    cnt_d   = '0;
                end else begin
                    cnt_d     = cnt_q + 8'd1;
                    tx_en_d   = 1'b1;
                    tx_data_d = ~crc_q[3:0];
                    crc_d     = crc_q >> 4;
                    done_d    = (cnt_d == 8'd7);
                end
            end
            S_ABORT: begin
                state_d = S_IFG;
                cnt_d   = '0;
            end
            S_IFG: begin
                if (cnt_q == IFG_LAST) state_d = S_IDLE;
                else                   cnt_d   = cnt_q + 8'd1;
            end
            default: state_d = S_IDLE;
        endcase

        // Actions shared by several states: load a byte, abort, pad nibble, FCS start.
        if (take_byte) begin
            state_d      = S_DATA;
            half_d       = 1'b0;
            hi_d         = i_data[7:4];
            last_d       = i_last;
            tx_en_d      = 1'b1;
            tx_data_d    = i_data[3:0];
            crc_d        = crc_nib(crc_q, i_data[3:0]);
            byte_count_d = (byte_count_q == '1) ? byte_count_q : byte_count_q + 11'd1;
        end
        if (abort) begin
            state_d    = S_ABORT;
            tx_en_d    = 1'b1;
            tx_er_d    = 1'b1;
            tx_data_d  = '0;
            underrun_d = 1'b1;
        end
        if (pad_nib) begin
            state_d   = S_PAD;
            tx_en_d   = 1'b1;
            tx_data_d = '0;
            crc_d     = crc_nib(crc_q, 4'h0);
        end
        if (start_fcs) begin
            state_d   = S_FCS;
            cnt_d     = '0;
            tx_en_d   = 1'b1;
            tx_data_d = ~crc_q[3:0];
            crc_d     = crc_q >> 4;
        end
    end

    always_ff @(posedge i_clk or negedge i_nreset) begin
        if (!i_nreset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            half_q       <= 1'b0;
            last_q       <= 1'b0;
            hi_q         <= '0;
            byte_count_q <= '0;
            crc_q        <= '0;
            tx_en_q      <= 1'b0;
            tx_er_q      <= 1'b0;
            tx_data_q    <= '0;
            underrun_q   <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            half_q       <= half_d;
            last_q       <= last_d;
            hi_q         <= hi_d;
            byte_count_q <= byte_count_d;
            crc_q        <= crc_d;
            tx_en_q      <= tx_en_d;
            tx_er_q      <= tx_er_d;
            tx_data_q    <= tx_data_d;
            underrun_q   <= underrun_d;
            done_q       <= done_d;
        end
    end

    assign o_busy       = (state_q != S_IDLE);
    assign o_underrun   = underrun_q;
    assign o_frame_done = done_q;
    assign enet_tx_en   = tx_en_q;
    assign enet_tx_er   = tx_er_q;
    assign enet_tx_data = tx_data_q;

endmodule

// File: tb/tb_mii_tx_framer.sv
// Bench for mii_tx_framer: random payloads driven on the byte stream, PHY nibbles
// captured every cycle and compared with an Ethernet frame model built from the payload.
module tb_mii_tx_framer;

    localparam int MIN_PL = 60;

    logic       i_clk = 1'b0;
    logic       i_nreset;
    logic [7:0] i_data;
    logic       i_valid;
    logic       i_last;
    logic       o_ready, o_busy, o_underrun, o_frame_done;
    logic       enet_tx_en, enet_tx_er;
    logic [3:0] enet_tx_data;

    int total = 0;
    int bad   = 0;

    typedef logic [7:0] byte_q_t[$];
    typedef logic [3:0] nib_q_t[$];
    typedef struct packed {
        logic       en;
        logic       er;
        logic [3:0] d;
        logic       rdy;
        logic       busy;
        logic       urun;
        logic       done;
    } samp_t;

    samp_t trace[$];

    mii_tx_framer #(.MIN_PAYLOAD(60), .IFG_NIBBLES(24), .PREAMBLE_NIBBLES(15)) dut (
        .i_clk(i_clk), .i_nreset(i_nreset), .i_data(i_data), .i_valid(i_valid),
        .i_last(i_last), .o_ready(o_ready), .o_busy(o_busy), .o_underrun(o_underrun),
        .o_frame_done(o_frame_done), .enet_tx_en(enet_tx_en), .enet_tx_er(enet_tx_er),
        .enet_tx_data(enet_tx_data)
    );

    always #20 i_clk = ~i_clk;

    always @(negedge i_clk)
        trace.push_back({enet_tx_en, enet_tx_er, enet_tx_data, o_ready, o_busy,
                         o_underrun, o_frame_done});

    initial begin
        #2_400_000;
        $display("FAIL watchdog: observed=hang expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] crc_bytes(input byte_q_t b);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (b[i]) begin
            c = c ^ {24'h0, b[i]};
            repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    task automatic gen(input int n, output byte_q_t q);
        q.delete();
        repeat (n) q.push_back(8'($urandom));
    endtask

    // Reference frame: preamble, SFD, payload padded to minimum, then ~CRC LSB nibble first.
    task automatic model_frame(input byte_q_t pl, output nib_q_t e);
        byte_q_t     p;
        logic [31:0] fcs;
        p = pl;
        while (p.size() < MIN_PL) p.push_back(8'h00);
        fcs = ~crc_bytes(p);
        e.delete();
        repeat (15) e.push_back(4'h5);
        e.push_back(4'hd);
        foreach (p[i]) begin
            e.push_back(p[i][3:0]);
            e.push_back(p[i][7:4]);
        end
        for (int i = 0; i < 8; i++) e.push_back(fcs[4*i +: 4]);
    endtask

    task automatic send(input byte_q_t b, input int la, input int gap_at, input int reset_nib);
        int k = 0, cyc = 0, gap = 0, nib = 0;
        bit hs, stop = 0;
        i_valid = 1'b1;
        i_data  = b[0];
        i_last  = (la == 0) || (b.size() == 1);
        while (k < b.size() && cyc < 20000 && !stop) begin
            @(negedge i_clk);
            hs = i_valid && o_ready;
            if (reset_nib >= 0 && enet_tx_en) begin
                nib++;
                if (nib > reset_nib) begin
                    i_nreset = 1'b0;
                    stop     = 1'b1;
                end
            end
            if (!stop) begin
                @(posedge i_clk);
                #1;
                cyc++;
                if (hs) begin
                    k++;
                    if (k == gap_at) gap = 3;
                end
                if (gap > 0) begin
                    i_valid = 1'b0;
                    gap--;
                end else if (k < b.size()) begin
                    i_valid = 1'b1;
                    i_data  = b[k];
                    i_last  = (k == la) || (k == b.size() - 1);
                end
            end
        end
        i_valid = 1'b0;
        i_last  = 1'b0;
        if (cyc >= 20000) chk("send_timeout", 32'(k), 32'(b.size()));
    endtask

    task automatic wait_idle(input string tag);
        int c = 0;
        while (o_busy && c < 5000) begin
            @(negedge i_clk);
            c++;
        end
        chk({tag, "_idle_reached"}, 32'(o_busy), 32'd0);
        repeat (3) @(negedge i_clk);
    endtask

    task automatic find_run(input int from, output int s, output int len);
        s   = -1;
        len = 0;
        for (int i = from; i < trace.size(); i++) begin
            if (trace[i].en) begin
                if (s < 0) s = i;
                len++;
            end else if (s >= 0) begin
                break;
            end
        end
        if (s < 0) s = 0;
    endtask

    task automatic check_frame(input string tag, input byte_q_t pl, input int s, input int len);
        nib_q_t  e;
        byte_q_t rx;
        int      mism = 0, nd = 0, ner = 0, lastpos;
        model_frame(pl, e);
        chk({tag, "_len"}, 32'(len), 32'(e.size()));
        for (int i = 0; i < len && i < e.size(); i++)
            if (trace[s+i].d !== e[i]) mism++;
        chk({tag, "_nibble_mismatches"}, 32'(mism), 32'd0);
        for (int j = 0; j < (len - 16) / 2; j++)
            rx.push_back({trace[s+16+2*j+1].d, trace[s+16+2*j].d});
        chk({tag, "_crc_residue"}, crc_bytes(rx), 32'hDEBB20E3);
        for (int i = 0; i < len; i++) begin
            if (trace[s+i].done) nd++;
            if (trace[s+i].er)   ner++;
        end
        lastpos = (len > 0) ? s + len - 1 : s;
        chk({tag, "_done_count"}, 32'(nd), 32'd1);
        chk({tag, "_done_on_last"}, 32'(trace[lastpos].done), 32'd1);
        chk({tag, "_tx_er_count"}, 32'(ner), 32'd0);
    endtask

    // o_ready legal only on the SFD cycle or on high-nibble cycles of the first hi_bytes bytes.
    task automatic check_ready(input string tag, input int s, input int len, input int hi_bytes,
                               output int nrdy);
        int bad_pos = 0, idle_rdy = 0, idx;
        nrdy = 0;
        for (int i = 0; i < len; i++) begin
            idx = i;
            if (trace[s+i].rdy) begin
                nrdy++;
                if (!(idx == 15 || (idx >= 17 && (idx % 2) == 1 && idx <= 15 + 2*hi_bytes)))
                    bad_pos++;
            end
        end
        foreach (trace[i]) if (trace[i].rdy && !trace[i].en) idle_rdy++;
        chk({tag, "_ready_position"}, 32'(bad_pos), 32'd0);
        chk({tag, "_ready_while_idle"}, 32'(idle_rdy), 32'd0);
    endtask

    initial begin
        int      s, l, s2, l2, nr, mism, nur;
        byte_q_t p, a, b, all, rest;
        nib_q_t  e;

        i_nreset = 1'b0;
        i_valid  = 1'b0;
        i_last   = 1'b0;
        i_data   = 8'h00;
        repeat (3) @(negedge i_clk);
        chk("rst_tx_en", 32'(enet_tx_en), 32'd0);
        chk("rst_tx_er", 32'(enet_tx_er), 32'd0);
        chk("rst_tx_data", 32'(enet_tx_data), 32'd0);
        chk("rst_ready", 32'(o_ready), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_underrun", 32'(o_underrun), 32'd0);
        chk("rst_done", 32'(o_frame_done), 32'd0);
        i_nreset = 1'b1;
        repeat (3) @(negedge i_clk);
        chk("idle_busy", 32'(o_busy), 32'd0);

        // 60-byte gap-free frame
        gen(60, p);
        trace.delete();
        send(p, -1, -1, -1);
        wait_idle("f60");
        find_run(0, s, l);
        check_frame("f60", p, s, l);
        check_ready("f60", s, l, 59, nr);
        chk("f60_ready_count", 32'(nr), 32'd60);

        // 10-byte frame padded to minimum
        gen(10, p);
        trace.delete();
        send(p, -1, -1, -1);
        wait_idle("f10");
        find_run(0, s, l);
        check_frame("f10", p, s, l);
        check_ready("f10", s, l, 9, nr);
        chk("f10_ready_count", 32'(nr), 32'd10);

        // 100 bytes with a 3-cycle valid gap at byte 40: abort, then bytes 40..99 as a new frame
        gen(100, p);
        trace.delete();
        send(p, -1, 40, -1);
        wait_idle("abort");
        find_run(0, s, l);
        chk("abort_len", 32'(l), 32'd97);
        chk("abort_last_er", 32'(trace[s+l-1].er), 32'd1);
        chk("abort_last_data", 32'(trace[s+l-1].d), 32'd0);
        chk("abort_underrun_on_last", 32'(trace[s+l-1].urun), 32'd1);
        model_frame(p, e);
        mism = 0;
        for (int i = 0; i < 96 && i < l; i++) if (trace[s+i].d !== e[i]) mism++;
        chk("abort_partial_mismatches", 32'(mism), 32'd0);
        nur = 0;
        foreach (trace[i]) if (trace[i].urun) nur++;
        chk("abort_underrun_pulses", 32'(nur), 32'd1);
        check_ready("abort", s, l, 40, nr);
        chk("abort_ready_count", 32'(nr), 32'd41);
        find_run(s + l, s2, l2);
        chk("abort_gap", 32'(s2 - (s + l)), 32'd24);
        rest.delete();
        for (int i = 40; i < 100; i++) rest.push_back(p[i]);
        check_frame("after_abort", rest, s2, l2);

        // back-to-back 64-byte frames, i_valid never dropped
        gen(64, a);
        gen(64, b);
        all.delete();
        foreach (a[i]) all.push_back(a[i]);
        foreach (b[i]) all.push_back(b[i]);
        trace.delete();
        send(all, 63, -1, -1);
        wait_idle("b2b");
        find_run(0, s, l);
        find_run(s + l, s2, l2);
        check_frame("b2b_first", a, s, l);
        chk("b2b_gap", 32'(s2 - (s + l)), 32'd24);
        check_frame("b2b_second", b, s2, l2);

        // reset asserted while nibble 50 is on the wire
        gen(60, p);
        trace.delete();
        send(p, -1, -1, 50);
        #1;
        chk("midrst_tx_en", 32'(enet_tx_en), 32'd0);
        chk("midrst_tx_er", 32'(enet_tx_er), 32'd0);
        chk("midrst_tx_data", 32'(enet_tx_data), 32'd0);
        chk("midrst_ready", 32'(o_ready), 32'd0);
        chk("midrst_busy", 32'(o_busy), 32'd0);
        chk("midrst_underrun", 32'(o_underrun), 32'd0);
        chk("midrst_done", 32'(o_frame_done), 32'd0);
        repeat (2) @(negedge i_clk);
        i_nreset = 1'b1;
        repeat (2) @(negedge i_clk);
        chk("postrst_tx_en", 32'(enet_tx_en), 32'd0);
        gen(60, p);
        trace.delete();
        send(p, -1, -1, -1);
        wait_idle("postrst");
        find_run(0, s, l);
        check_frame("postrst", p, s, l);

        // random lengths 60..1514
        for (int it = 0; it < 3; it++) begin
            gen(int'($urandom_range(1514, 60)), p);
            trace.delete();
            send(p, -1, -1, -1);
            wait_idle("rand");
            find_run(0, s, l);
            check_frame("rand", p, s, l);
            check_ready("rand", s, l, p.size() - 1, nr);
            chk("rand_ready_count", 32'(nr), 32'(p.size()));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
